// File: rtl/router_pkg.sv
// router_pkg: types and helpers shared by the router input stage.
//   flit_t     - packed flit {is_head, is_tail, dest_x, dest_y, data}
//   LOCAL..WEST - output port indices (bit positions in one-hot requests)
//   xy_route   - dimension-ordered (X then Y) route to a one-hot port vector
package router_pkg;

  localparam int COORD_W   = 4;
  localparam int DATA_W    = 32;
  localparam int NUM_PORTS = 5;

  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int EAST  = 2;
  localparam int SOUTH = 3;
  localparam int WEST  = 4;

  typedef struct packed {
    logic               is_head;
    logic               is_tail;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic [DATA_W-1:0]  data;
  } flit_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ipu_state_t;

  function automatic logic [NUM_PORTS-1:0] xy_route(
    input logic [COORD_W-1:0] dx,
    input logic [COORD_W-1:0] dy,
    input logic [COORD_W-1:0] x_loc,
    input logic [COORD_W-1:0] y_loc
  );
    logic [NUM_PORTS-1:0] r;
    r = '0;
    if (dx > x_loc)      r[EAST]  = 1'b1;
    else if (dx < x_loc) r[WEST]  = 1'b1;
    else if (dy > y_loc) r[NORTH] = 1'b1;
    else if (dy < y_loc) r[SOUTH] = 1'b1;
    else                 r[LOCAL] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/input_port_unit_flit_fifo.sv
// flit_fifo: flit storage for one router input.
//   clk, reset_n       - clock, async active-low reset (flushes pointers)
//   wr_en, wr_data     - push (caller guarantees not full)
//   rd_en              - pop head (caller guarantees not empty)
//   rd_data            - head entry, 0 when empty
//   count, full, empty - occupancy
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module flit_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  flit_t                    wr_data,
  input  logic                     rd_en,
  output flit_t                    rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  flit_t        mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/input_port_unit.sv
// input_port_unit: buffered router input with XY route and wormhole lock.
//   clk, reset_n   - clock, async active-low reset
//   ce             - clock enable for every state update
//   i_flit/i_valid - incoming flit
//   o_en           - free slots, saturated at 15
//   o_flit         - FIFO head toward the crossbar (0 when empty)
//   o_output_req   - one-hot output request toward the allocator
//   i_input_grant  - grant for this input; pops the head flit
//   o_err          - sticky protocol-error flag
//   o_pkt_count    - granted tail flits, saturating (only with PKT_COUNT_EN)
// Optional feature macro: PKT_COUNT_EN.
//
// state     | meaning
// ST_IDLE   | no packet in flight; head flit must be a head, requests route
// ST_ACTIVE | packet locked to lock_q; requests lock_q until tail is granted
module input_port_unit
  import router_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int X_LOC = 0,
  parameter int Y_LOC = 0,
  parameter int M     = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ce,
  input  flit_t        i_flit,
  input  logic         i_valid,
  output logic [3:0]   o_en,
  output flit_t        o_flit,
  output logic [M-1:0] o_output_req,
  input  logic         i_input_grant,
`ifdef PKT_COUNT_EN
  output logic [15:0]  o_pkt_count,
`endif
  output logic         o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [COORD_W-1:0] X_C = COORD_W'(X_LOC);
  localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_LOC);

  ipu_state_t   state_q, state_d;
  logic [M-1:0] lock_q, lock_d;
  logic [M-1:0] req;
  logic [M-1:0] route_head;
  flit_t        head;
  logic [AW:0]  count;
  logic [4:0]   free;
  logic         full, empty;
  logic         wr_en, rd_en;
  logic         grant_ok, discard, active_head, err_set;
  logic         err_q;

  flit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (i_flit),
    .rd_en   (rd_en),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign route_head = xy_route(head.dest_x, head.dest_y, X_C, Y_C);

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    req         = '0;
    discard     = 1'b0;
    active_head = 1'b0;
    grant_ok    = 1'b0;
    err_set     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (head.is_head) req = route_head;
          else              discard = 1'b1;  // orphan body/tail flit is dropped
        end
      end
      ST_ACTIVE: begin
        if (!empty) begin
          req         = lock_q;
          active_head = head.is_head;        // new head mid-packet: forwarded as body
        end
      end
      default: ;
    endcase
    grant_ok = i_input_grant && !empty && (req != '0);
    if (grant_ok) begin
      if (state_q == ST_IDLE && !head.is_tail) begin
        state_d = ST_ACTIVE;
        lock_d  = route_head;
      end else if (state_q == ST_ACTIVE && head.is_tail) begin
        state_d = ST_IDLE;
        lock_d  = '0;
      end
    end
    err_set = (i_valid && full) || discard || (i_input_grant && !grant_ok) || active_head;
  end

  // Full check uses the pre-pop occupancy, so a write at full is rejected
  // even when the head leaves in the same cycle.
  assign wr_en = ce && i_valid && !full;
  assign rd_en = ce && (grant_ok || discard);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
      err_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      lock_q  <= lock_d;
      if (err_set) err_q <= 1'b1;
    end
  end

`ifdef PKT_COUNT_EN
  logic [15:0] pkt_cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pkt_cnt_q <= '0;
    else if (ce && grant_ok && head.is_tail && pkt_cnt_q != 16'hFFFF)
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end
  assign o_pkt_count = pkt_cnt_q;
`endif

  assign free         = 5'(DEPTH) - 5'(count);
  assign o_en         = (free > 5'd15) ? 4'hF : free[3:0];
  assign o_flit       = head;
  assign o_output_req = req;
  assign o_err        = err_q;

endmodule
